sram_dp: RTL and testbench



---
 rtl/sram_dp.sv | 130 +++++++++++++
 tb/tb_sram_dp.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_dp.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sram_dp : two pipelined Wishbone slave ports sharing one single-port RAM
// Revision: 1.0
// ----------------------------------------------------------------------------
module sram_dp #(
  parameter int  SIZE      = 2,
  parameter int  DELAY     = 0,
  parameter      SRCFILE   = "",
  parameter int  ARCHBITSZ = 16,
  localparam int ADDRBITSZ = ARCHBITSZ - $clog2(ARCHBITSZ / 8)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   wb0_cyc_i,
  input  logic                   wb0_stb_i,
  input  logic                   wb0_we_i,
  input  logic [ADDRBITSZ-1:0]   wb0_addr_i,
  input  logic [ARCHBITSZ/8-1:0] wb0_sel_i,
  input  logic [ARCHBITSZ-1:0]   wb0_dat_i,
  output logic                   wb0_bsy_o,
  output logic                   wb0_ack_o,
  output logic [ARCHBITSZ-1:0]   wb0_dat_o,
  input  logic                   wb1_cyc_i,
  input  logic                   wb1_stb_i,
  input  logic                   wb1_we_i,
  input  logic [ADDRBITSZ-1:0]   wb1_addr_i,
  input  logic [ARCHBITSZ/8-1:0] wb1_sel_i,
  input  logic [ARCHBITSZ-1:0]   wb1_dat_i,
  output logic                   wb1_bsy_o,
  output logic                   wb1_ack_o,
  output logic [ARCHBITSZ-1:0]   wb1_dat_o,
  output logic [ARCHBITSZ-1:0]   mmapsz_o
);
  localparam int   c_nb      = ARCHBITSZ / 8;
  localparam int   c_iw      = $clog2(SIZE);
  localparam int   c_cw      = (DELAY > 0) ? $clog2(DELAY + 1) : 1;
  localparam logic c_has_dly = (DELAY > 0);

  logic [ARCHBITSZ-1:0] mem [SIZE];

  logic                 w_req0, w_req1, w_free, w_gnt0, w_gnt1, w_acc;
  logic                 w_we, w_issue, w_unused_addr;
  logic [c_iw-1:0]      w_idx;
  logic [c_nb-1:0]      w_sel;
  logic [ARCHBITSZ-1:0] w_mask, w_dat, w_rdat, w_wdat;

  logic [c_cw-1:0]      cntr_q, cntr_d;
  logic                 last_q, last_d;
  logic                 pend0_q, pend0_d, pend1_q, pend1_d;
  logic                 ack0_q, ack0_d, ack1_q, ack1_d;
  logic [ARCHBITSZ-1:0] dat0_q, dat0_d, dat1_q, dat1_d;

  assign w_unused_addr = ^{wb0_addr_i, wb1_addr_i};

  assign w_req0 = wb0_cyc_i & wb0_stb_i;
  assign w_req1 = wb1_cyc_i & wb1_stb_i;
  assign w_free = (cntr_q == '0);
  // Under contention the port that did not win last time gets the slot.
  assign w_gnt0 = w_free & w_req0 & (~w_req1 | last_q);
  assign w_gnt1 = w_free & w_req1 & (~w_req0 | ~last_q);
  assign w_acc  = w_gnt0 | w_gnt1;

  assign wb0_bsy_o = w_req0 & ~w_gnt0;
  assign wb1_bsy_o = w_req1 & ~w_gnt1;
  assign wb0_ack_o = ack0_q;
  assign wb1_ack_o = ack1_q;
  assign wb0_dat_o = dat0_q;
  assign wb1_dat_o = dat1_q;
  assign mmapsz_o  = ARCHBITSZ'(SIZE * c_nb);

  always_comb begin
    w_we   = w_gnt1 ? wb1_we_i : wb0_we_i;
    w_idx  = w_gnt1 ? wb1_addr_i[c_iw-1:0] : wb0_addr_i[c_iw-1:0];
    w_sel  = w_gnt1 ? wb1_sel_i : wb0_sel_i;
    w_dat  = w_gnt1 ? wb1_dat_i : wb0_dat_i;
    w_mask = '0;
    for (int b = 0; b < c_nb; b++) begin
      w_mask[b*8 +: 8] = {8{w_sel[b]}};
    end
    w_rdat = mem[w_idx];
    w_wdat = (w_dat & w_mask) | (w_rdat & ~w_mask);
  end

  always_comb begin
    cntr_d = cntr_q;
    last_d = last_q;
    if (cntr_q != '0) cntr_d = cntr_q - c_cw'(1);
    if (w_acc) begin
      cntr_d = c_cw'(DELAY);
      last_d = w_gnt1;
    end
    // Pending state retires on the last busy cycle even if the master left.
    w_issue = (cntr_q == c_cw'(1));
    pend0_d = (pend0_q & ~w_issue) | (w_gnt0 & c_has_dly);
    pend1_d = (pend1_q & ~w_issue) | (w_gnt1 & c_has_dly);
    ack0_d  = c_has_dly ? (pend0_q & w_issue & wb0_cyc_i) : w_gnt0;
    ack1_d  = c_has_dly ? (pend1_q & w_issue & wb1_cyc_i) : w_gnt1;
    dat0_d  = (w_gnt0 & ~wb0_we_i) ? w_rdat : dat0_q;
    dat1_d  = (w_gnt1 & ~wb1_we_i) ? w_rdat : dat1_q;
  end

  always_ff @(posedge clk_i) begin
    if (w_acc && w_we) mem[w_idx] <= w_wdat;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cntr_q  <= '0;
      last_q  <= 1'b1;
      pend0_q <= 1'b0;
      pend1_q <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      dat0_q  <= '0;
      dat1_q  <= '0;
    end else begin
      cntr_q  <= cntr_d;
      last_q  <= last_d;
      pend0_q <= pend0_d;
      pend1_q <= pend1_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      dat0_q  <= dat0_d;
      dat1_q  <= dat1_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_dp.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_sram_dp : directed vectors for sram_dp (32-bit/DELAY=0 and 16-bit/DELAY=3)
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_sram_dp;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: ARCHBITSZ=32, DELAY=0, SIZE=8
  logic        a_rst_n;
  logic        a_cyc [2], a_stb [2], a_we [2], a_bsy [2], a_ack [2];
  logic [29:0] a_addr [2];
  logic [3:0]  a_sel [2];
  logic [31:0] a_dati [2], a_dato [2];
  logic [31:0] a_mmap;

  // Instance B: ARCHBITSZ=16, DELAY=3, SIZE=4
  logic        b_rst_n;
  logic        b_cyc [2], b_stb [2], b_we [2], b_bsy [2], b_ack [2];
  logic [14:0] b_addr [2];
  logic [1:0]  b_sel [2];
  logic [15:0] b_dati [2], b_dato [2];
  logic [15:0] b_mmap;

  sram_dp #(.SIZE(8), .DELAY(0), .SRCFILE(""), .ARCHBITSZ(32)) dut_a (
    .clk_i(clk), .rst_ni(a_rst_n),
    .wb0_cyc_i(a_cyc[0]), .wb0_stb_i(a_stb[0]), .wb0_we_i(a_we[0]),
    .wb0_addr_i(a_addr[0]), .wb0_sel_i(a_sel[0]), .wb0_dat_i(a_dati[0]),
    .wb0_bsy_o(a_bsy[0]), .wb0_ack_o(a_ack[0]), .wb0_dat_o(a_dato[0]),
    .wb1_cyc_i(a_cyc[1]), .wb1_stb_i(a_stb[1]), .wb1_we_i(a_we[1]),
    .wb1_addr_i(a_addr[1]), .wb1_sel_i(a_sel[1]), .wb1_dat_i(a_dati[1]),
    .wb1_bsy_o(a_bsy[1]), .wb1_ack_o(a_ack[1]), .wb1_dat_o(a_dato[1]),
    .mmapsz_o(a_mmap)
  );

  sram_dp #(.SIZE(4), .DELAY(3), .SRCFILE(""), .ARCHBITSZ(16)) dut_b (
    .clk_i(clk), .rst_ni(b_rst_n),
    .wb0_cyc_i(b_cyc[0]), .wb0_stb_i(b_stb[0]), .wb0_we_i(b_we[0]),
    .wb0_addr_i(b_addr[0]), .wb0_sel_i(b_sel[0]), .wb0_dat_i(b_dati[0]),
    .wb0_bsy_o(b_bsy[0]), .wb0_ack_o(b_ack[0]), .wb0_dat_o(b_dato[0]),
    .wb1_cyc_i(b_cyc[1]), .wb1_stb_i(b_stb[1]), .wb1_we_i(b_we[1]),
    .wb1_addr_i(b_addr[1]), .wb1_sel_i(b_sel[1]), .wb1_dat_i(b_dati[1]),
    .wb1_bsy_o(b_bsy[1]), .wb1_ack_o(b_ack[1]), .wb1_dat_o(b_dato[1]),
    .mmapsz_o(b_mmap)
  );

  typedef struct {
    int          port;
    bit          we;
    logic [29:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdat;
    logic [31:0] exp;
    string       name;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One access on instance B with full byte lanes; expects acceptance at once
  // and the ack in the 4th cycle after acceptance.
  task automatic b_access(input int p, input bit we, input logic [14:0] addr,
                          input logic [15:0] d, input logic [15:0] exp, input string name);
    int n;
    @(negedge clk);
    b_cyc[p] = 1'b1; b_stb[p] = 1'b1; b_we[p] = we;
    b_addr[p] = addr; b_dati[p] = d; b_sel[p] = 2'b11;
    #1;
    chk({name, " bsy"}, 64'(b_bsy[p]), 64'(0));
    @(negedge clk);
    b_stb[p] = 1'b0;
    n = 1;
    #1;
    while (!b_ack[p] && n < 10) begin
      @(negedge clk); #1; n++;
    end
    chk({name, " ack latency"}, 64'(n), 64'(4));
    if (!we) chk({name, " data"}, 64'(b_dato[p]), 64'(exp));
    @(negedge clk); #1;
    chk({name, " ack pulse"}, 64'(b_ack[p]), 64'(0));
    b_cyc[p] = 1'b0;
  endtask

  vec_t        vecs [12];
  logic [31:0] mdat [2];

  initial begin
    for (int p = 0; p < 2; p++) begin
      a_cyc[p] = 1'b1; a_stb[p] = 1'b1; a_we[p] = 1'b0;
      a_addr[p] = '0; a_sel[p] = '0; a_dati[p] = '0;
      b_cyc[p] = 1'b1; b_stb[p] = 1'b1; b_we[p] = 1'b0;
      b_addr[p] = '0; b_sel[p] = '0; b_dati[p] = '0;
      mdat[p] = '0;
    end
    a_rst_n = 1'b0;
    b_rst_n = 1'b0;

    vecs[0]  = '{0, 1'b1, 30'd5,  4'hF, 32'hAABBCCDD, 32'h0,        "w5 full"};
    vecs[1]  = '{0, 1'b1, 30'd5,  4'h5, 32'h11223344, 32'h0,        "w5 lanes0101"};
    vecs[2]  = '{1, 1'b0, 30'd5,  4'hF, 32'h0,        32'hAA22CC44, "r5 merged"};
    vecs[3]  = '{0, 1'b1, 30'd3,  4'hF, 32'h12345678, 32'h0,        "w3 full"};
    vecs[4]  = '{1, 1'b1, 30'd3,  4'h0, 32'hDEADBEEF, 32'h0,        "w3 sel0"};
    vecs[5]  = '{0, 1'b0, 30'd3,  4'hF, 32'h0,        32'h12345678, "r3 after sel0"};
    vecs[6]  = '{1, 1'b1, 30'd2,  4'hF, 32'h00000000, 32'h0,        "w2 clear"};
    vecs[7]  = '{1, 1'b1, 30'd2,  4'hA, 32'hCAFEF00D, 32'h0,        "w2 lanes1010"};
    vecs[8]  = '{0, 1'b0, 30'd2,  4'hF, 32'h0,        32'hCA00F000, "r2 merged"};
    vecs[9]  = '{1, 1'b1, 30'd13, 4'hF, 32'h0BADC0DE, 32'h0,        "w13 alias"};
    vecs[10] = '{1, 1'b0, 30'd5,  4'hF, 32'h0,        32'h0BADC0DE, "r5 alias"};
    vecs[11] = '{0, 1'b0, 30'd11, 4'hF, 32'h0,        32'h12345678, "r11 alias"};

    // Reset held with both ports requesting
    repeat (3) @(negedge clk);
    #1;
    for (int p = 0; p < 2; p++) begin
      chk("A rst ack", 64'(a_ack[p]), 64'(0));
      chk("A rst dat", 64'(a_dato[p]), 64'(0));
      chk("B rst ack", 64'(b_ack[p]), 64'(0));
      chk("B rst dat", 64'(b_dato[p]), 64'(0));
    end
    for (int p = 0; p < 2; p++) begin
      a_cyc[p] = 1'b0; a_stb[p] = 1'b0;
      b_cyc[p] = 1'b0; b_stb[p] = 1'b0;
    end
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;
    @(negedge clk); #1;
    for (int p = 0; p < 2; p++) begin
      chk("A idle bsy", 64'(a_bsy[p]), 64'(0));
      chk("A idle ack", 64'(a_ack[p]), 64'(0));
      chk("B idle bsy", 64'(b_bsy[p]), 64'(0));
      chk("B idle ack", 64'(b_ack[p]), 64'(0));
    end
    chk("A mmapsz", 64'(a_mmap), 64'(32));
    chk("B mmapsz", 64'(b_mmap), 64'(8));

    // Table-driven single accesses on instance A
    for (int i = 0; i < 12; i++) begin
      int p, o;
      p = vecs[i].port;
      o = 1 - p;
      @(negedge clk);
      a_cyc[p] = 1'b1; a_stb[p] = 1'b1; a_we[p] = vecs[i].we;
      a_addr[p] = vecs[i].addr; a_sel[p] = vecs[i].sel; a_dati[p] = vecs[i].wdat;
      #1;
      chk({vecs[i].name, " bsy"}, 64'(a_bsy[p]), 64'(0));
      @(negedge clk);
      a_cyc[p] = 1'b0; a_stb[p] = 1'b0;
      if (!vecs[i].we) mdat[p] = vecs[i].exp;
      #1;
      chk({vecs[i].name, " ack"}, 64'(a_ack[p]), 64'(1));
      chk({vecs[i].name, " dat"}, 64'(a_dato[p]), 64'(mdat[p]));
      chk({vecs[i].name, " other dat"}, 64'(a_dato[o]), 64'(mdat[o]));
      @(negedge clk); #1;
      chk({vecs[i].name, " ack pulse"}, 64'(a_ack[p]), 64'(0));
    end

    // Contention on A straight from reset: grants 0,1,0,1,0,1
    begin
      int nack0, nack1;
      nack0 = 0; nack1 = 0;
      @(negedge clk);
      a_rst_n = 1'b0;
      @(negedge clk);
      a_rst_n = 1'b1;
      a_cyc[0] = 1'b1; a_stb[0] = 1'b1; a_we[0] = 1'b0; a_addr[0] = 30'd5;
      a_cyc[1] = 1'b1; a_stb[1] = 1'b1; a_we[1] = 1'b0; a_addr[1] = 30'd3;
      for (int k = 0; k < 6; k++) begin
        #1;
        chk("contend bsy0", 64'(a_bsy[0]), 64'(k % 2));
        chk("contend bsy1", 64'(a_bsy[1]), 64'(1 - (k % 2)));
        chk("contend ack0", 64'(a_ack[0]), 64'((k > 0) && ((k - 1) % 2 == 0)));
        chk("contend ack1", 64'(a_ack[1]), 64'((k > 0) && ((k - 1) % 2 == 1)));
        if (a_ack[0] === 1'b1) nack0++;
        if (a_ack[1] === 1'b1) nack1++;
        @(negedge clk);
      end
      for (int p = 0; p < 2; p++) begin
        a_cyc[p] = 1'b0; a_stb[p] = 1'b0;
      end
      #1;
      chk("contend last ack1", 64'(a_ack[1]), 64'(1));
      chk("contend last ack0", 64'(a_ack[0]), 64'(0));
      if (a_ack[1] === 1'b1) nack1++;
      if (a_ack[0] === 1'b1) nack0++;
      chk("contend count ack0", 64'(nack0), 64'(3));
      chk("contend count ack1", 64'(nack1), 64'(3));
      chk("contend dat0", 64'(a_dato[0]), 64'(32'h0BADC0DE));
      chk("contend dat1", 64'(a_dato[1]), 64'(32'h12345678));
    end

    // Instance B, DELAY=3
    b_access(0, 1'b1, 15'd1, 16'h1234, 16'h0, "B w1");

    // Port1 read accepted; port0 arrives one cycle later and must wait
    @(negedge clk);
    b_cyc[1] = 1'b1; b_stb[1] = 1'b1; b_we[1] = 1'b0; b_addr[1] = 15'd1;
    #1;
    chk("B delay bsy1", 64'(b_bsy[1]), 64'(0));
    @(negedge clk);
    b_stb[1] = 1'b0;
    b_cyc[0] = 1'b1; b_stb[0] = 1'b1; b_we[0] = 1'b0; b_addr[0] = 15'd1;
    for (int n = 1; n <= 9; n++) begin
      if (n == 5) begin
        b_stb[0] = 1'b0;
        b_cyc[1] = 1'b0;
      end
      #1;
      chk("B delay bsy0", 64'(b_bsy[0]), 64'(n <= 3));
      chk("B delay ack1", 64'(b_ack[1]), 64'(n == 4));
      chk("B delay ack0", 64'(b_ack[0]), 64'(n == 8));
      if (n == 4) chk("B delay dat1", 64'(b_dato[1]), 64'(16'h1234));
      if (n == 8) chk("B delay dat0", 64'(b_dato[0]), 64'(16'h1234));
      @(negedge clk);
    end
    b_cyc[0] = 1'b0;

    // Address wrap modulo SIZE=4
    b_access(1, 1'b0, 15'd5, 16'h0, 16'h1234, "B r5 wrap");
    b_access(0, 1'b0, 15'd9, 16'h0, 16'h1234, "B r9 wrap");

    // Master drops cyc after acceptance: no ack, next access normal
    @(negedge clk);
    b_cyc[0] = 1'b1; b_stb[0] = 1'b1; b_we[0] = 1'b0; b_addr[0] = 15'd1;
    #1;
    chk("B abort bsy0", 64'(b_bsy[0]), 64'(0));
    @(negedge clk);
    b_cyc[0] = 1'b0; b_stb[0] = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      #1;
      chk("B abort no ack0", 64'(b_ack[0]), 64'(0));
      @(negedge clk);
    end
    b_access(0, 1'b1, 15'd3, 16'h5A5A, 16'h0, "B w3 after abort");
    b_access(1, 1'b0, 15'd3, 16'h0, 16'h5A5A, "B r3 after abort");

    // Reset two cycles into an accepted write: no ack, data persists
    @(negedge clk);
    b_cyc[0] = 1'b1; b_stb[0] = 1'b1; b_we[0] = 1'b1;
    b_addr[0] = 15'd2; b_dati[0] = 16'hBEEF; b_sel[0] = 2'b11;
    #1;
    chk("B rstmid bsy0", 64'(b_bsy[0]), 64'(0));
    @(negedge clk);
    b_stb[0] = 1'b0;
    @(negedge clk);
    b_rst_n = 1'b0;
    @(negedge clk);
    b_rst_n = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      #1;
      chk("B rstmid no ack0", 64'(b_ack[0]), 64'(0));
      @(negedge clk);
    end
    b_cyc[0] = 1'b0;
    chk("B rstmid dat0 cleared", 64'(b_dato[0]), 64'(0));
    b_access(1, 1'b0, 15'd2, 16'h0, 16'hBEEF, "B r2 after reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
